// File: rtl/conv1d_pkg.sv
// Shared definitions for the conv1d requantisation output stage: config
// select codes, integer limits, the pipeline stage record and a helper
// that folds the raw 6-bit shift field into the usable range.
package conv1d_pkg;

    localparam int MAX_CHANNELS = 128;
    localparam int CH_W         = $clog2(MAX_CHANNELS);

    localparam logic [2:0] CFG_SEL_BIAS       = 3'd0;
    localparam logic [2:0] CFG_SEL_MULT       = 3'd1;
    localparam logic [2:0] CFG_SEL_SHIFT      = 3'd2;
    localparam logic [2:0] CFG_SEL_OUT_OFFSET = 3'd3;
    localparam logic [2:0] CFG_SEL_ACT_MIN    = 3'd4;
    localparam logic [2:0] CFG_SEL_ACT_MAX    = 3'd5;

    localparam logic signed [7:0]  INT8_MIN  = 8'sh80;
    localparam logic signed [7:0]  INT8_MAX  = 8'sh7F;
    localparam logic signed [31:0] INT32_MIN = 32'sh8000_0000;

    // One pipeline slot: the beat's channel, its running value and the
    // pending right-shift amount for the final rounding divide.
    typedef struct packed {
        logic                valid;
        logic [CH_W-1:0]     channel;
        logic signed [31:0]  value;
        logic [4:0]          rs;
    } stage_t;

    // The shift field is 6-bit signed; -32 is not a legal shift and is
    // pulled in to -31 so both shift directions stay within 31 bits.
    function automatic logic signed [5:0] sat_shift(input logic [5:0] raw);
        return (raw == 6'b100000) ? 6'sb100001 : $signed(raw);
    endfunction

endpackage

// File: rtl/conv1d_requant_if.sv
// Valid/ready stream carrying a data word tagged with an output channel.
// Used for both the int32 accumulator input and the int8 result output.
interface conv1d_requant_if #(
    parameter int DATA_W = 32,
    parameter int CH_W   = conv1d_pkg::CH_W
);
    logic              valid;
    logic              ready;
    logic [DATA_W-1:0] data;
    logic [CH_W-1:0]   channel;

    modport master (output valid, output data, output channel, input ready);
    modport slave  (input valid, input data, input channel, output ready);
endinterface

// File: rtl/sat_rounding_doubling_high_mul.sv
// Combinational TFLite SaturatingRoundingDoublingHighMul: returns the
// rounded high half of 2*a*b, saturating the single overflow case
// INT32_MIN * INT32_MIN to INT32_MAX.
module sat_rounding_doubling_high_mul
    import conv1d_pkg::*;
(
    input  logic signed [31:0] a,
    input  logic signed [31:0] b,
    output logic signed [31:0] y
);

    logic signed [63:0] a64;
    logic signed [63:0] b64;
    logic signed [63:0] prod;
    logic signed [63:0] nudged;
    logic signed [63:0] biased;
    logic [31:0]        unused_bits;

    // Full product, round-half-away nudge, then divide by 2^31 toward zero
    // (negative values get 2^31-1 added before the arithmetic shift).
    always_comb begin
        a64    = {{32{a[31]}}, a};
        b64    = {{32{b[31]}}, b};
        prod   = a64 * b64;
        nudged = prod + (prod[63] ? 64'shFFFF_FFFF_C000_0001
                                  : 64'sh0000_0000_4000_0000);
        biased = nudged[63] ? (nudged + 64'sh0000_0000_7FFF_FFFF) : nudged;
        unused_bits = {biased[63], biased[30:0]};
        if ((a == INT32_MIN) && (b == INT32_MIN)) begin
            y = 32'sh7FFF_FFFF;
        end else begin
            y = biased[62:31];
        end
    end

endmodule

// File: rtl/conv1d_requant.sv
// Requantisation stage behind the conv1d accumulator: per-channel bias,
// fixed-point multiply and shift, output offset and activation clamp,
// as a 4-deep stallable pipeline sharing a single advance enable.
module conv1d_requant
    import conv1d_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              cfg_we,
    input  logic [2:0]        cfg_sel,
    input  logic [CH_W-1:0]   cfg_addr,
    input  logic [31:0]       cfg_data,
    conv1d_requant_if.slave   in_s,
    conv1d_requant_if.master  out_s,
    output logic              busy
);

    logic signed [31:0] bias_tab  [MAX_CHANNELS];
    logic signed [31:0] mult_tab  [MAX_CHANNELS];
    logic signed [5:0]  shift_tab [MAX_CHANNELS];

    logic signed [31:0] out_offset;
    logic signed [7:0]  act_min;
    logic signed [7:0]  act_max;

    stage_t             s0, s1, s2;
    logic [4:0]         s0_lsh;
    logic signed [31:0] s0_mult, s1_mult;

    logic               out_valid;
    logic signed [7:0]  out_data;
    logic [CH_W-1:0]    out_channel;

    logic               en;
    logic signed [5:0]  fetch_shift;
    logic signed [31:0] fetch_x0;
    logic [4:0]         fetch_lsh, fetch_rs;

    logic signed [31:0] x2;
    logic signed [31:0] x2q, x3, y, min32, max32;
    logic [31:0]        mask, rem, thr;
    logic signed [7:0]  clamped;

    assign en          = !out_valid || out_s.ready;
    assign in_s.ready  = en && reset;
    assign out_s.valid = out_valid;
    assign out_s.data  = out_data;
    assign out_s.channel = out_channel;
    assign busy        = s0.valid || s1.valid || s2.valid || out_valid;

    // Per-channel tables: written by the command decoder, never reset.
    always_ff @(posedge clk) begin
        if (cfg_we) begin
            case (cfg_sel)
                CFG_SEL_BIAS:  bias_tab[cfg_addr]  <= cfg_data;
                CFG_SEL_MULT:  mult_tab[cfg_addr]  <= cfg_data;
                CFG_SEL_SHIFT: shift_tab[cfg_addr] <= sat_shift(cfg_data[5:0]);
                default: ;
            endcase
        end
    end

    // Global output parameters, restored to a pass-through range on reset.
    always_ff @(posedge clk) begin
        if (!reset) begin
            out_offset <= '0;
            act_min    <= INT8_MIN;
            act_max    <= INT8_MAX;
        end else if (cfg_we) begin
            case (cfg_sel)
                CFG_SEL_OUT_OFFSET: out_offset <= cfg_data;
                CFG_SEL_ACT_MIN:    act_min    <= cfg_data[7:0];
                CFG_SEL_ACT_MAX:    act_max    <= cfg_data[7:0];
                default: ;
            endcase
        end
    end

    // Parameter fetch for the incoming beat; split the shift into its
    // left-shift and pending right-shift parts.
    always_comb begin
        fetch_shift = shift_tab[in_s.channel];
        fetch_x0    = in_s.data + bias_tab[in_s.channel];
        fetch_lsh   = fetch_shift[5] ? 5'd0 : fetch_shift[4:0];
        fetch_rs    = fetch_shift[5] ? 5'(-fetch_shift) : 5'd0;
    end

    sat_rounding_doubling_high_mul u_srdhm (
        .a (s1.value),
        .b (s1_mult),
        .y (x2)
    );

    // Rounding divide by 2^rs, output offset and activation clamp; a
    // reversed clamp range always yields act_max.
    always_comb begin
        x2q   = s2.value;
        mask  = (32'd1 << s2.rs) - 32'd1;
        rem   = x2q & mask;
        thr   = (mask >> 1) + {31'd0, x2q[31]};
        x3    = (x2q >>> s2.rs) + ((rem > thr) ? 32'sd1 : 32'sd0);
        y     = x3 + out_offset;
        min32 = 32'(act_min);
        max32 = 32'(act_max);
        if ((y > max32) || (min32 > max32)) begin
            clamped = act_max;
        end else if (y < min32) begin
            clamped = act_min;
        end else begin
            clamped = y[7:0];
        end
    end

    // Pipeline advance: every stage moves together whenever the output
    // slot is empty or being drained; reset drops all in-flight beats.
    always_ff @(posedge clk) begin
        if (!reset) begin
            s0.valid    <= 1'b0;
            s1.valid    <= 1'b0;
            s2.valid    <= 1'b0;
            out_valid   <= 1'b0;
            out_data    <= '0;
            out_channel <= '0;
        end else if (en) begin
            s0.valid    <= in_s.valid;
            s0.channel  <= in_s.channel;
            s0.value    <= fetch_x0;
            s0.rs       <= fetch_rs;
            s0_lsh      <= fetch_lsh;
            s0_mult     <= mult_tab[in_s.channel];

            s1.valid    <= s0.valid;
            s1.channel  <= s0.channel;
            s1.value    <= s0.value << s0_lsh;
            s1.rs       <= s0.rs;
            s1_mult     <= s0_mult;

            s2.valid    <= s1.valid;
            s2.channel  <= s1.channel;
            s2.value    <= x2;
            s2.rs       <= s1.rs;

            out_valid   <= s2.valid;
            out_data    <= clamped;
            out_channel <= s2.channel;
        end
    end

endmodule

// File: tb/tb_conv1d_requant.sv
// Directed bench for conv1d_requant with hand-computed expected results.
module tb_conv1d_requant;
    import conv1d_pkg::*;

    logic            clk;
    logic            reset;
    logic            cfg_we;
    logic [2:0]      cfg_sel;
    logic [CH_W-1:0] cfg_addr;
    logic [31:0]     cfg_data;
    logic            busy;

    int check_count;
    int pass_count;

    conv1d_requant_if #(.DATA_W(32), .CH_W(CH_W)) in_if ();
    conv1d_requant_if #(.DATA_W(8),  .CH_W(CH_W)) out_if ();

    conv1d_requant dut (
        .clk      (clk),
        .reset    (reset),
        .cfg_we   (cfg_we),
        .cfg_sel  (cfg_sel),
        .cfg_addr (cfg_addr),
        .cfg_data (cfg_data),
        .in_s     (in_if),
        .out_s    (out_if),
        .busy     (busy)
    );

    // Free-running 100 MHz clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Hard stop if the run ever stalls.
    initial begin
        #500000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input int actual, input int expected);
        check_count++;
        if (actual == expected) pass_count++;
        else $display("[TB] FAIL %s: got %0d, expected %0d", tag, actual, expected);
    endtask

    task automatic write_cfg(input logic [2:0] sel, input int addr, input logic [31:0] data);
        @(negedge clk);
        cfg_we   = 1'b1;
        cfg_sel  = sel;
        cfg_addr = CH_W'(addr);
        cfg_data = data;
        @(negedge clk);
        cfg_we   = 1'b0;
    endtask

    task automatic config_channel(input int ch, input logic [31:0] bias,
                                  input logic [31:0] mult, input logic [31:0] shift);
        write_cfg(CFG_SEL_BIAS,  ch, bias);
        write_cfg(CFG_SEL_MULT,  ch, mult);
        write_cfg(CFG_SEL_SHIFT, ch, shift);
    endtask

    // Waits, from the negedge after an accept, for the result; edges counts
    // rising edges including the accept edge.
    task automatic wait_output(output int data, output int chan, output int edges);
        edges = 1;
        while (!out_if.valid && edges < 20) begin
            @(posedge clk);
            edges++;
            @(negedge clk);
        end
        data = int'($signed(out_if.data));
        chan = int'(out_if.channel);
    endtask

    task automatic applyStimulus(input int acc, input int ch,
                                 output int data, output int chan, output int edges);
        @(negedge clk);
        out_if.ready   = 1'b1;
        in_if.valid    = 1'b1;
        in_if.data     = acc;
        in_if.channel  = CH_W'(ch);
        @(negedge clk);
        in_if.valid    = 1'b0;
        wait_output(data, chan, edges);
    endtask

    initial begin
        int d, c, e;
        int sent, got, cyc, accepts_at_stall, unstable, late_valid;
        int stall_data, stall_chan;
        bit stall_seen;
        int got_data [8];
        int got_chan [8];

        check_count = 0;
        pass_count  = 0;
        reset       = 1'b0;
        cfg_we      = 1'b0;
        cfg_sel     = '0;
        cfg_addr    = '0;
        cfg_data    = '0;
        in_if.valid   = 1'b0;
        in_if.data    = '0;
        in_if.channel = '0;
        out_if.ready  = 1'b1;

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        checkOutput("rst_in_ready", int'(in_if.ready), 0);
        checkOutput("rst_out_valid", int'(out_if.valid), 0);
        checkOutput("rst_busy", int'(busy), 0);
        checkOutput("rst_out_data", int'(out_if.data), 0);
        checkOutput("rst_out_channel", int'(out_if.channel), 0);
        reset = 1'b1;
        #1;
        checkOutput("post_rst_in_ready", int'(in_if.ready), 1);

        // Basic path: 100 -> 50 -> 25, offset -5
        config_channel(3, 32'h0, 32'h4000_0000, 32'hFFFF_FFFF);
        write_cfg(CFG_SEL_OUT_OFFSET, 0, 32'hFFFF_FFFB);
        applyStimulus(100, 3, d, c, e);
        checkOutput("basic_data", d, 20);
        checkOutput("basic_channel", c, 3);
        checkOutput("basic_latency_edges", e, 4);
        write_cfg(CFG_SEL_OUT_OFFSET, 0, 32'h0);

        // Rounding
        config_channel(1, 32'h0, 32'h4000_0000, 32'h0);
        applyStimulus(3, 1, d, c, e);
        checkOutput("round_pos", d, 2);
        write_cfg(CFG_SEL_SHIFT, 1, 32'hFFFF_FFFF);
        applyStimulus(-6, 1, d, c, e);
        checkOutput("round_neg", d, -2);

        // Saturation and clamp
        config_channel(2, 32'h0, 32'h8000_0000, 32'h0);
        applyStimulus(32'sh8000_0000, 2, d, c, e);
        checkOutput("sat_min_min", d, 127);
        write_cfg(CFG_SEL_MULT, 2, 32'h4000_0000);
        write_cfg(CFG_SEL_ACT_MAX, 0, 32'd100);
        applyStimulus(1000, 2, d, c, e);
        checkOutput("clamp_max", d, 100);
        write_cfg(CFG_SEL_ACT_MIN, 0, 32'd5);
        applyStimulus(3, 2, d, c, e);
        checkOutput("clamp_min", d, 5);
        write_cfg(CFG_SEL_ACT_MIN, 0, 32'd50);
        write_cfg(CFG_SEL_ACT_MAX, 0, 32'd10);
        applyStimulus(3, 2, d, c, e);
        checkOutput("clamp_reversed", d, 10);
        write_cfg(CFG_SEL_ACT_MIN, 0, 32'h80);
        write_cfg(CFG_SEL_ACT_MAX, 0, 32'd127);

        // Positive shift
        config_channel(4, 32'h0, 32'h4000_0000, 32'd2);
        applyStimulus(10, 4, d, c, e);
        checkOutput("lshift", d, 20);
        write_cfg(CFG_SEL_BIAS, 4, 32'hFFFF_FFF6);
        applyStimulus(10, 4, d, c, e);
        checkOutput("lshift_bias", d, 0);

        // Backpressure: 8 beats, consumer stalled for the first 10 cycles
        config_channel(5, 32'h0, 32'h4000_0000, 32'h0);
        sent = 0; got = 0; cyc = 0; accepts_at_stall = -1; unstable = 0;
        stall_seen = 1'b0; stall_data = 0; stall_chan = 0;
        while ((sent < 8 || got < 8) && cyc < 80) begin
            @(negedge clk);
            out_if.ready = (cyc >= 10);
            if (sent < 8) begin
                in_if.valid   = 1'b1;
                in_if.data    = 10 * (sent + 1);
                in_if.channel = CH_W'(5);
            end else begin
                in_if.valid = 1'b0;
            end
            #1;
            if (!in_if.ready && accepts_at_stall < 0) accepts_at_stall = sent;
            if (cyc < 10 && out_if.valid) begin
                if (!stall_seen) begin
                    stall_seen = 1'b1;
                    stall_data = int'($signed(out_if.data));
                    stall_chan = int'(out_if.channel);
                end else if (int'($signed(out_if.data)) != stall_data ||
                             int'(out_if.channel) != stall_chan) begin
                    unstable++;
                end
            end
            if (out_if.valid && out_if.ready && got < 8) begin
                got_data[got] = int'($signed(out_if.data));
                got_chan[got] = int'(out_if.channel);
                got++;
            end
            if (in_if.valid && in_if.ready) sent++;
            cyc++;
        end
        in_if.valid  = 1'b0;
        out_if.ready = 1'b1;
        checkOutput("bp_accepts_before_stall", accepts_at_stall, 4);
        checkOutput("bp_stall_unstable", unstable, 0);
        checkOutput("bp_sent", sent, 8);
        checkOutput("bp_received", got, 8);
        for (int i = 0; i < got; i++) begin
            checkOutput($sformatf("bp_data%0d", i), got_data[i], 5 * (i + 1));
            checkOutput($sformatf("bp_chan%0d", i), got_chan[i], 5);
        end

        // Reset with three beats in flight
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            in_if.valid   = 1'b1;
            in_if.data    = 20 * (i + 1);
            in_if.channel = CH_W'(5);
        end
        @(negedge clk);
        in_if.valid = 1'b0;
        checkOutput("inflight_busy", int'(busy), 1);
        reset = 1'b0;
        @(negedge clk);
        checkOutput("midrst_out_valid", int'(out_if.valid), 0);
        checkOutput("midrst_busy", int'(busy), 0);
        checkOutput("midrst_in_ready", int'(in_if.ready), 0);
        reset = 1'b1;
        late_valid = 0;
        repeat (6) begin
            @(negedge clk);
            if (out_if.valid) late_valid++;
        end
        checkOutput("dropped_beats", late_valid, 0);

        // Tables survive reset; offset returns to 0
        applyStimulus(100, 3, d, c, e);
        checkOutput("table_retained", d, 25);

        // Config write racing an accept on the same channel
        config_channel(0, 32'h0, 32'h4000_0000, 32'h0);
        @(negedge clk);
        out_if.ready  = 1'b1;
        cfg_we        = 1'b1;
        cfg_sel       = CFG_SEL_MULT;
        cfg_addr      = '0;
        cfg_data      = 32'h0;
        in_if.valid   = 1'b1;
        in_if.data    = 100;
        in_if.channel = '0;
        @(negedge clk);
        cfg_we      = 1'b0;
        in_if.valid = 1'b0;
        wait_output(d, c, e);
        checkOutput("race_old_mult", d, 50);
        applyStimulus(100, 0, d, c, e);
        checkOutput("race_new_mult", d, 0);

        $display("%0d/%0d checks passed", pass_count, check_count);
        $finish;
    end

endmodule
